mini_alu_core: RTL and testbench
================================

# mini_alu_core

Parametrised successor to the current MiniAlu datapath: a multi-cycle instruction core with a width-generic register file, a bounded hardware stack with fault detection, and a generic valid/ready peripheral write port that replaces per-peripheral stall wiring (LCD, VGA RAM, LEDs). It sits between the instruction ROM (combinational, addressed by `oIP`) and the peripheral decode logic at top level. It executes one instruction per FETCH/EXEC pair and stalls only on peripheral backpressure.

## Interface

Parameters:
- `DATA_W`, default 16: register, ALU and port data width.
- `ADDR_W`, default 16: instruction address width; `oIP` wraps modulo 2^ADDR_W.
- `REG_AW`, default 4: register index bits. NREGS = 2^REG_AW. Register NREGS-1 is RA.
- `STACK_DEPTH`, default 16: stack entries, any value ≥ 2.

Ports:
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high.
- `iInstr` in 30: instruction word at `oIP`, formatted {op[29:24], dst[23:16], s1[15:8], s0[7:0]}.
- `oIP` out ADDR_W: instruction address.
- `oPortValid` out 1: peripheral write request.
- `oPortAddr` out 8: peripheral select, taken from the dst field.
- `oPortData` out DATA_W: write data, R[s1].
- `iPortReady` in 1: peripheral accepts when high together with valid.
- `oStackFault` out 1: sticky, set on overflow or underflow.
- `oHalted` out 1: core stopped in HALT.

## Operation

- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, MUL=5, STO=6, BLE=7, JMP=8, CALL=9, RET=10, PUSH=11, POP=12, OUT=13, HLT=14. Undefined opcodes execute as NOP.
- Register indices use the low REG_AW bits of each field.
- ALU ops compute R[dst] = R[s1] op R[s0], truncated to DATA_W.
- STO: R[dst] = {s1,s0}, zero-extended or truncated to DATA_W.
- BLE: branch if R[s1] ≤ R[s0], unsigned. Target is the dst field, zero-extended.
- JMP: IP = dst.
- CALL: RA = IP+1, then IP = dst.
- RET: IP = R[s0][ADDR_W-1:0].
- PUSH: stack ← R[s0].
- POP: R[dst] ← top of stack.
- OUT: drive the port and wait for the handshake.
- HLT: enter HALT.
- FSM states: FETCH, EXEC, WAIT_IO, HALT.
  - FETCH: latch `iInstr`, go to EXEC.
  - EXEC: commit the result, update IP (IP+1 or the branch target), go to FETCH. OUT goes to WAIT_IO instead.
  - WAIT_IO: `oPortValid`=1. On `iPortReady`, IP+1 and go to FETCH.
  - HALT: terminal until Reset.
- Stack boundaries:
  - PUSH while count == STACK_DEPTH: no write, set `oStackFault`, go to HALT.
  - POP while count == 0: R[dst] unchanged, set the fault, go to HALT.
  - PUSH to exactly full is legal.
- Port rules:
  - `oPortAddr` and `oPortData` stay stable while valid is high.
  - Valid never drops without a handshake, except on Reset.
- Reset, including mid-operation:
  - State returns to FETCH, IP to 0, all registers to 0, stack count to 0.
  - All outputs go to 0. A pending port request is abandoned.

## Timing

- Non-OUT instruction: 2 cycles (FETCH + EXEC). Register writes are visible to the next instruction.
- OUT: 2 + N cycles, where N ≥ 1 is the number of cycles until ready is sampled high in WAIT_IO. If ready is already high, OUT takes exactly 3 cycles.
- `oIP` is registered and changes only on the EXEC→FETCH or WAIT_IO→FETCH edge.
- `oStackFault` and `oHalted` assert on the same edge as the transition into HALT.

## Configuration

- `MINI_ALU_MUL_EN` defined: MUL computes the low DATA_W bits of R[s1]*R[s0] in EXEC (single cycle).
- Not defined: MUL decodes as NOP. No multiplier is inferred.

## Structure

- Shared package `mini_alu_pkg`:
  - opcode constants;
  - FSM state encoding;
  - instruction field positions;
  - RA index helper.
- One sub-module, `mini_alu_stack`: parametrised LIFO with push/pop, full/empty, and count outputs. The core owns fault detection.

## Test plan

- STO R1,5; STO R2,3; SUB R3,R1,R2 → R3=2. SUB R4,R2,R1 → R4=0xFFFE (DATA_W=16). Each instruction takes 2 cycles.
- STO R1,7; BLE 0x20,R1,R1 → `oIP`=0x20. With R1=8, R2=7, BLE 0x20,R1,R2 falls through to IP+1.
- CALL 0x10 at IP 4; at 0x10, RET R15 → RA=5, then `oIP`=5.
- STACK_DEPTH=2: PUSH R1 three times → `oStackFault`=1 and `oHalted`=1 after the third. POP on an empty stack after Reset gives the same result.
- OUT 0x03,R1 with R1=0xAB and ready held low for 4 cycles → valid high with addr 3 and data 0xAB stable throughout; IP advances only after ready. Reset asserted during the wait → valid=0 and `oIP`=0 immediately.
- MUL R3,R1,R2 with R1=0x100, R2=0x100: with the macro → R3=0; R1=3, R2=5 → R3=15. Without the macro → R3 unchanged.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini_alu core: opcodes, FSM encoding,
// instruction field layout and the return-address register helper.
package mini_alu_pkg;

    // Instruction word layout: {op, dst, s1, s0}
    localparam int unsigned INSTR_W = 30;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned OP_LSB  = 24;
    localparam int unsigned DST_LSB = 16;
    localparam int unsigned S1_LSB  = 8;
    localparam int unsigned S0_LSB  = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W-1:0] OP_MUL  = 6'd5;
    localparam logic [OP_W-1:0] OP_STO  = 6'd6;
    localparam logic [OP_W-1:0] OP_BLE  = 6'd7;
    localparam logic [OP_W-1:0] OP_JMP  = 6'd8;
    localparam logic [OP_W-1:0] OP_CALL = 6'd9;
    localparam logic [OP_W-1:0] OP_RET  = 6'd10;
    localparam logic [OP_W-1:0] OP_PUSH = 6'd11;
    localparam logic [OP_W-1:0] OP_POP  = 6'd12;
    localparam logic [OP_W-1:0] OP_OUT  = 6'd13;
    localparam logic [OP_W-1:0] OP_HLT  = 6'd14;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_WAIT_IO = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // Return-address register is the highest-numbered register.
    function automatic int unsigned ra_index(input int unsigned reg_aw);
        return (32'd1 << reg_aw) - 32'd1;
    endfunction

endpackage

// File: rtl/mini_alu_stack.sv
// Parametrised LIFO used as the core's hardware stack. Push/pop requests
// that would overflow/underflow are ignored here; the core detects them.
// Ports: Clock, Reset (async, active-high), push, pop, push_data,
//        top_c (current top, 0 when empty), full_c, empty_c, count.
module mini_alu_stack
    import mini_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign wr_ptr  = PTR_W'(count);
    assign rd_ptr  = PTR_W'(count - CNT_W'(1));
    assign top_c   = empty_c ? '0 : mem[rd_ptr];

    // Occupancy counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (push && !full_c) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty_c) begin
            count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries above count are never read
    always_ff @(posedge Clock) begin
        if (push && !full_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// Multi-cycle mini ALU core: FETCH/EXEC per instruction, register file,
// bounded hardware stack with sticky fault, valid/ready peripheral port.
// Optional macro MINI_ALU_MUL_EN enables the single-cycle MUL opcode;
// without it MUL executes as NOP and no multiplier exists.
// Ports: Clock, Reset (async, active-high), iInstr (ROM word at oIP), oIP,
//        oPortValid/oPortAddr/oPortData/iPortReady (peripheral write),
//        oStackFault (sticky stack fault), oHalted (core in HALT).
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] iInstr,
    output logic [ADDR_W-1:0]  oIP,
    output logic               oPortValid,
    output logic [7:0]         oPortAddr,
    output logic [DATA_W-1:0]  oPortData,
    input  logic               iPortReady,
    output logic               oStackFault,
    output logic               oHalted
);

    localparam int unsigned NREGS = 32'd1 << REG_AW;
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [REG_AW-1:0] RA_IDX = REG_AW'(ra_index(REG_AW));

    state_t state, state_nxt;

    logic [INSTR_W-1:0] instr, instr_nxt;
    logic [OP_W-1:0]    op;
    logic [FIELD_W-1:0] dst_f, s1_f, s0_f;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [DATA_W-1:0]  rs1, rs0, alu_res;
    logic [ADDR_W-1:0]  ip_inc, ip_nxt;

    logic               wr_en;
    logic [REG_AW-1:0]  wr_idx;
    logic [DATA_W-1:0]  wr_data;

    logic               valid_nxt, fault_nxt, halted_nxt;
    logic [7:0]         addr_nxt;
    logic [DATA_W-1:0]  data_nxt;

    logic               stk_push, stk_pop, stk_full_c, stk_empty_c;
    logic [DATA_W-1:0]  stk_top_c;
    logic [CNT_W-1:0]   stk_count;
    logic               unused_stk_count;

    assign op     = instr[OP_LSB  +: OP_W];
    assign dst_f  = instr[DST_LSB +: FIELD_W];
    assign s1_f   = instr[S1_LSB  +: FIELD_W];
    assign s0_f   = instr[S0_LSB  +: FIELD_W];
    assign rs1    = regs[s1_f[REG_AW-1:0]];
    assign rs0    = regs[s0_f[REG_AW-1:0]];
    assign ip_inc = oIP + ADDR_W'(1);

    // Count is exported by the stack for observability; faults use full/empty.
    assign unused_stk_count = ^stk_count;

    mini_alu_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (rs0),
        .top_c     (stk_top_c),
        .full_c    (stk_full_c),
        .empty_c   (stk_empty_c),
        .count     (stk_count)
    );

    // ALU
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = rs1 + rs0;
            OP_SUB: alu_res = rs1 - rs0;
            OP_AND: alu_res = rs1 & rs0;
            OP_OR:  alu_res = rs1 | rs0;
`ifdef MINI_ALU_MUL_EN
            OP_MUL: alu_res = rs1 * rs0;
`endif
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt  = state;
        instr_nxt  = instr;
        ip_nxt     = oIP;
        wr_en      = 1'b0;
        wr_idx     = dst_f[REG_AW-1:0];
        wr_data    = alu_res;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        valid_nxt  = oPortValid;
        addr_nxt   = oPortAddr;
        data_nxt   = oPortData;
        fault_nxt  = oStackFault;
        halted_nxt = oHalted;

        case (state)
            ST_FETCH: begin
                instr_nxt = iInstr;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                ip_nxt    = ip_inc;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: wr_en = 1'b1;
`ifdef MINI_ALU_MUL_EN
                    OP_MUL: wr_en = 1'b1;
                    OP_NOP: ;
`else
                    OP_NOP, OP_MUL: ;
`endif
                    OP_STO: begin
                        wr_en   = 1'b1;
                        wr_data = DATA_W'({s1_f, s0_f});
                    end
                    OP_BLE: begin
                        if (rs1 <= rs0) ip_nxt = ADDR_W'(dst_f);
                    end
                    OP_JMP: ip_nxt = ADDR_W'(dst_f);
                    OP_CALL: begin
                        wr_en   = 1'b1;
                        wr_idx  = RA_IDX;
                        wr_data = DATA_W'(ip_inc);
                        ip_nxt  = ADDR_W'(dst_f);
                    end
                    OP_RET: ip_nxt = ADDR_W'(rs0);
                    OP_PUSH: begin
                        if (stk_full_c) begin
                            fault_nxt  = 1'b1;
                            halted_nxt = 1'b1;
                            state_nxt  = ST_HALT;
                            ip_nxt     = oIP;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (stk_empty_c) begin
                            fault_nxt  = 1'b1;
                            halted_nxt = 1'b1;
                            state_nxt  = ST_HALT;
                            ip_nxt     = oIP;
                        end else begin
                            stk_pop = 1'b1;
                            wr_en   = 1'b1;
                            wr_data = stk_top_c;
                        end
                    end
                    OP_OUT: begin
                        // Address/data latched once here, held until handshake
                        state_nxt = ST_WAIT_IO;
                        ip_nxt    = oIP;
                        valid_nxt = 1'b1;
                        addr_nxt  = dst_f;
                        data_nxt  = rs1;
                    end
                    OP_HLT: begin
                        state_nxt  = ST_HALT;
                        halted_nxt = 1'b1;
                        ip_nxt     = oIP;
                    end
                    default: ;
                endcase
            end
            ST_WAIT_IO: begin
                if (iPortReady) begin
                    valid_nxt = 1'b0;
                    ip_nxt    = ip_inc;
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_FETCH;
        else       state <= state_nxt;
    end

    // Datapath and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            instr       <= '0;
            oIP         <= '0;
            oPortValid  <= 1'b0;
            oPortAddr   <= '0;
            oPortData   <= '0;
            oStackFault <= 1'b0;
            oHalted     <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regs[REG_AW'(i)] <= '0;
        end else begin
            instr       <= instr_nxt;
            oIP         <= ip_nxt;
            oPortValid  <= valid_nxt;
            oPortAddr   <= addr_nxt;
            oPortData   <= data_nxt;
            oStackFault <= fault_nxt;
            oHalted     <= halted_nxt;
            if (wr_en) regs[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mini_alu_core.sv
// Self-checking bench for mini_alu_core: small programs in a ROM model,
// expected port writes queued in a scoreboard and checked on handshake.
module tb_mini_alu_core;
    import mini_alu_pkg::*;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned REG_AW      = 4;
    localparam int unsigned STACK_DEPTH = 2;
    localparam int unsigned NVEC        = 10;

    logic               Clock = 1'b0;
    logic               Reset = 1'b1;
    logic [INSTR_W-1:0] iInstr;
    logic [ADDR_W-1:0]  oIP;
    logic               oPortValid;
    logic [7:0]         oPortAddr;
    logic [DATA_W-1:0]  oPortData;
    logic               iPortReady;
    logic               oStackFault;
    logic               oHalted;

    logic               ready = 1'b1;
    logic [INSTR_W-1:0] rom [256];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } port_exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    port_exp_t sb[$];
    port_exp_t mon_e;
    vec_t      vt [NVEC];
    int        n_vec = 0;
    int        n_bad = 0;
    int        cyc;

    assign iInstr     = rom[oIP[7:0]];
    assign iPortReady = ready;

    mini_alu_core #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .REG_AW      (REG_AW),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iInstr      (iInstr),
        .oIP         (oIP),
        .oPortValid  (oPortValid),
        .oPortAddr   (oPortAddr),
        .oPortData   (oPortData),
        .iPortReady  (iPortReady),
        .oStackFault (oStackFault),
        .oHalted     (oHalted)
    );

    always #5 Clock = ~Clock;

    function automatic logic [INSTR_W-1:0] ins(input logic [5:0] op, input logic [7:0] d,
                                               input logic [7:0] s1, input logic [7:0] s0);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OP_LSB  +: OP_W]    = op;
        w[DST_LSB +: FIELD_W] = d;
        w[S1_LSB  +: FIELD_W] = s1;
        w[S0_LSB  +: FIELD_W] = s0;
        return w;
    endfunction

    function automatic logic [INSTR_W-1:0] sto(input logic [7:0] r, input logic [15:0] imm);
        return ins(OP_STO, r, imm[15:8], imm[7:0]);
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] e, input string nm);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = e; v.name = nm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_HLT, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("rst_ip",     32'(oIP),         32'h0);
        check("rst_valid",  32'(oPortValid),  32'h0);
        check("rst_addr",   32'(oPortAddr),   32'h0);
        check("rst_data",   32'(oPortData),   32'h0);
        check("rst_fault",  32'(oStackFault), 32'h0);
        check("rst_halted", 32'(oHalted),     32'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    // Negedges until oHalted, bounded; call right after do_reset or mid-run
    task automatic run_to_halt(input int max, output int cycles);
        cycles = 0;
        while (!oHalted && cycles < max) begin
            @(negedge Clock);
            cycles++;
        end
        if (!oHalted) begin
            n_vec++;
            n_bad++;
            $display("FAIL halt_timeout: no halt after %0d cycles, ip 0x%0h", cycles, oIP);
        end
    endtask

    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        while (!oPortValid && cycles < max) begin
            @(negedge Clock);
            cycles++;
        end
        if (!oPortValid) begin
            n_vec++;
            n_bad++;
            $display("FAIL valid_timeout: no port request after %0d cycles", cycles);
        end
    endtask

    // Scoreboard: each handshake pops the oldest expected write
    always @(negedge Clock) begin
        if (!Reset && oPortValid && iPortReady) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL port_write: unexpected addr 0x%0h data 0x%0h", oPortAddr, oPortData);
            end else begin
                mon_e = sb.pop_front();
                check("port_addr", 32'(oPortAddr), 32'(mon_e.addr));
                check("port_data", 32'(oPortData), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(OP_ADD, 16'h0005, 16'h0003, 16'h0008, "add");
        vt[1] = mk(OP_SUB, 16'h0005, 16'h0003, 16'h0002, "sub");
        vt[2] = mk(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, "sub_wrap");
        vt[3] = mk(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, "and");
        vt[4] = mk(OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, "or");
        vt[5] = mk(OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, "add_wrap");
`ifdef MINI_ALU_MUL_EN
        vt[6] = mk(OP_MUL, 16'h0100, 16'h0100, 16'h0000, "mul_trunc");
        vt[7] = mk(OP_MUL, 16'h0003, 16'h0005, 16'h000F, "mul");
`else
        vt[6] = mk(OP_MUL, 16'h0100, 16'h0100, 16'h0055, "mul_off");
        vt[7] = mk(OP_MUL, 16'h0003, 16'h0005, 16'h0055, "mul_off2");
`endif
        vt[8] = mk(OP_NOP, 16'h1234, 16'h4321, 16'h0055, "nop");
        vt[9] = mk(6'd63,  16'h1234, 16'h4321, 16'h0055, "undef_op");

        // ALU table: R3 preset, operands loaded, op into R3, R3 written out
        for (int i = 0; i < int'(NVEC); i++) begin
            clear_rom();
            rom[0] = sto(8'd3, 16'h0055);
            rom[1] = sto(8'd1, vt[i].a);
            rom[2] = sto(8'd2, vt[i].b);
            rom[3] = ins(vt[i].op, 8'd3, 8'd1, 8'd2);
            rom[4] = ins(OP_OUT, 8'h03, 8'd3, 8'd0);
            ready = 1'b1;
            sb.push_back('{8'h03, vt[i].exp});
            do_reset();
            run_to_halt(100, cyc);
            check({vt[i].name, "_cycles"}, 32'(cyc), 32'd14);
            check({vt[i].name, "_ip"},     32'(oIP), 32'h5);
            check({vt[i].name, "_fault"},  32'(oStackFault), 32'h0);
            check({vt[i].name, "_sb"},     32'(sb.size()), 32'h0);
        end

        // BLE taken (equal operands)
        clear_rom();
        rom[0]  = sto(8'd1, 16'h0007);
        rom[1]  = ins(OP_BLE, 8'h20, 8'd1, 8'd1);
        rom[2]  = ins(OP_OUT, 8'hEE, 8'd1, 8'd0);
        rom[32] = ins(OP_OUT, 8'h01, 8'd1, 8'd0);
        sb.push_back('{8'h01, 16'h0007});
        do_reset();
        repeat (4) @(negedge Clock);
        check("ble_ip_before", 32'(oIP), 32'h1);
        @(negedge Clock);
        check("ble_ip_taken", 32'(oIP), 32'h20);
        run_to_halt(50, cyc);
        check("ble_halt_ip", 32'(oIP), 32'h21);
        check("ble_sb", 32'(sb.size()), 32'h0);

        // BLE not taken (8 <= 7 false)
        clear_rom();
        rom[0]  = sto(8'd1, 16'h0008);
        rom[1]  = sto(8'd2, 16'h0007);
        rom[2]  = ins(OP_BLE, 8'h20, 8'd1, 8'd2);
        rom[3]  = ins(OP_OUT, 8'h02, 8'd1, 8'd0);
        rom[32] = ins(OP_OUT, 8'hEE, 8'd2, 8'd0);
        sb.push_back('{8'h02, 16'h0008});
        do_reset();
        run_to_halt(50, cyc);
        check("ble_nt_ip", 32'(oIP), 32'h4);
        check("ble_nt_sb", 32'(sb.size()), 32'h0);

        // CALL at 4, RET via R15, RA written out
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = ins(OP_NOP, 8'h00, 8'h00, 8'h00);
        rom[4]  = ins(OP_CALL, 8'h10, 8'h00, 8'h00);
        rom[5]  = ins(OP_OUT, 8'h05, 8'd15, 8'd0);
        rom[16] = ins(OP_RET, 8'h00, 8'h00, 8'd15);
        sb.push_back('{8'h05, 16'h0005});
        do_reset();
        repeat (11) @(negedge Clock);
        check("call_ip", 32'(oIP), 32'h10);
        run_to_halt(50, cyc);
        check("ret_halt_ip", 32'(oIP), 32'h6);
        check("call_sb", 32'(sb.size()), 32'h0);

        // Stack LIFO order, filled exactly to depth
        clear_rom();
        rom[0] = sto(8'd1, 16'h0011);
        rom[1] = sto(8'd2, 16'h0022);
        rom[2] = ins(OP_PUSH, 8'h00, 8'h00, 8'd1);
        rom[3] = ins(OP_PUSH, 8'h00, 8'h00, 8'd2);
        rom[4] = ins(OP_POP,  8'd3,  8'h00, 8'h00);
        rom[5] = ins(OP_POP,  8'd4,  8'h00, 8'h00);
        rom[6] = ins(OP_OUT,  8'h03, 8'd3,  8'd0);
        rom[7] = ins(OP_OUT,  8'h04, 8'd4,  8'd0);
        sb.push_back('{8'h03, 16'h0022});
        sb.push_back('{8'h04, 16'h0011});
        do_reset();
        run_to_halt(80, cyc);
        check("lifo_fault", 32'(oStackFault), 32'h0);
        check("lifo_ip", 32'(oIP), 32'h8);
        check("lifo_sb", 32'(sb.size()), 32'h0);

        // Overflow on third push
        clear_rom();
        rom[0] = sto(8'd1, 16'h0009);
        for (int i = 1; i < 4; i++) rom[i] = ins(OP_PUSH, 8'h00, 8'h00, 8'd1);
        rom[4] = ins(OP_OUT, 8'h09, 8'd1, 8'd0);
        do_reset();
        run_to_halt(50, cyc);
        check("ovf_fault", 32'(oStackFault), 32'h1);
        check("ovf_cycles", 32'(cyc), 32'd9);
        check("ovf_ip", 32'(oIP), 32'h3);
        repeat (3) @(negedge Clock);
        check("ovf_sticky", 32'(oStackFault), 32'h1);
        check("ovf_halted", 32'(oHalted), 32'h1);
        check("ovf_ip_hold", 32'(oIP), 32'h3);

        // Underflow on pop right after reset
        clear_rom();
        rom[0] = ins(OP_POP, 8'd3, 8'h00, 8'h00);
        rom[1] = ins(OP_OUT, 8'h03, 8'd3, 8'd0);
        do_reset();
        run_to_halt(50, cyc);
        check("unf_fault", 32'(oStackFault), 32'h1);
        check("unf_cycles", 32'(cyc), 32'd3);
        check("unf_ip", 32'(oIP), 32'h0);

        // OUT with ready held low: request stable, IP frozen
        clear_rom();
        rom[0] = sto(8'd1, 16'h00AB);
        rom[1] = ins(OP_OUT, 8'h03, 8'd1, 8'd0);
        ready = 1'b0;
        sb.push_back('{8'h03, 16'h00AB});
        do_reset();
        wait_valid(20, cyc);
        check("out_valid_lat", 32'(cyc), 32'd5);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge Clock);
            check("stall_valid", 32'(oPortValid), 32'h1);
            check("stall_addr",  32'(oPortAddr),  32'h03);
            check("stall_data",  32'(oPortData),  32'h00AB);
            check("stall_ip",    32'(oIP),        32'h1);
        end
        @(posedge Clock); #1;
        ready = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("out_done_valid", 32'(oPortValid), 32'h0);
        check("out_done_ip",    32'(oIP),        32'h2);
        run_to_halt(20, cyc);
        check("out_sb", 32'(sb.size()), 32'h0);

        // Reset in the middle of a pending port request
        ready = 1'b0;
        do_reset();
        wait_valid(20, cyc);
        repeat (2) @(negedge Clock);
        @(posedge Clock); #3;
        Reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(oPortValid), 32'h0);
        check("mid_rst_ip",    32'(oIP),        32'h0);
        check("mid_rst_data",  32'(oPortData),  32'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        ready = 1'b1;
        sb.push_back('{8'h03, 16'h00AB});
        run_to_halt(30, cyc);
        check("post_rst_ip", 32'(oIP), 32'h2);
        check("post_rst_sb", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
